// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared widths, op encodings and FSM states for the divide sequencer.
package div_ctrl_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    // op[1] selects remainder, op[0] selects unsigned
    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FIX,
        S_RESP
    } state_e;
endpackage

// File: rtl/div_ctrl_if.sv
// div_ctrl_if: EX-side request/response channel of the divide sequencer.
interface div_ctrl_if
    import div_ctrl_pkg::*;
();
    logic            req_valid_i;
    logic            req_ready_o;
    div_op_e         op_i;
    logic [XLEN-1:0] rs1_i;
    logic [XLEN-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic            stall_o;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_data_o;
    logic [4:0]      resp_rd_o;
    modport master (
        output req_valid_i, op_i, rs1_i, rs2_i, rd_i, resp_ready_i,
        input  req_ready_o, stall_o, resp_valid_o, resp_data_o, resp_rd_o
    );
    modport slave (
        input  req_valid_i, op_i, rs1_i, rs2_i, rd_i, resp_ready_i,
        output req_ready_o, stall_o, resp_valid_o, resp_data_o, resp_rd_o
    );
endinterface

// File: rtl/div_sign_fix.sv
// div_sign_fix: restores signs on the unsigned core result and selects quotient or remainder.
module div_sign_fix
    import div_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] rem,
    input  logic            sign1,
    input  logic            sign2,
    input  logic            is_signed,
    input  logic            is_rem,
    output logic [XLEN-1:0] res
);
    logic [XLEN-1:0] q_fix;
    logic [XLEN-1:0] r_fix;
    always_comb begin
        q_fix = (is_signed & (sign1 ^ sign2)) ? -quot : quot;
        r_fix = (is_signed & sign1) ? -rem : rem;
        res   = is_rem ? r_fix : q_fix;
    end
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: sequences RV32M divides through an external unsigned core, handling
// divide-by-zero and signed overflow locally and fixing up signs of the result.
module div_ctrl
    import div_ctrl_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            flush_i,
    div_ctrl_if.slave       bus,
    output logic            core_start_o,
    output logic            core_abort_o,
    output logic [XLEN-1:0] core_dividend_o,
    output logic [XLEN-1:0] core_divisor_o,
    input  logic            core_done_i,
    input  logic [XLEN-1:0] core_quot_i,
    input  logic [XLEN-1:0] core_rem_i
);
    state_e          state_q, state_d;
    logic            accept, sgn, neg1, neg2, is_div0, is_ovf, special;
    logic            s1_q, s2_q, start_q;
    logic [1:0]      op_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] q_q, r_q, res_q, fix_res, special_res;

    assign bus.req_ready_o  = (state_q == S_IDLE);
    assign bus.stall_o      = (state_q != S_IDLE);
    assign bus.resp_valid_o = (state_q == S_RESP);
    assign bus.resp_data_o  = res_q;
    assign bus.resp_rd_o    = rd_q;
    assign core_start_o     = start_q;
    assign core_abort_o     = flush_i & (state_q == S_WAIT);

    always_comb begin
        sgn         = ~bus.op_i[0];
        neg1        = sgn & bus.rs1_i[XLEN-1];
        neg2        = sgn & bus.rs2_i[XLEN-1];
        accept      = bus.req_valid_i & (state_q == S_IDLE) & ~flush_i;
        is_div0     = (bus.rs2_i == '0);
        is_ovf      = sgn & (bus.rs1_i == INT_MIN) & (bus.rs2_i == '1);
        special     = is_div0 | is_ovf;
        // divide-by-zero wins: remainder passes rs1 through untouched
        special_res = is_div0 ? (bus.op_i[1] ? bus.rs1_i : '1)
                              : (bus.op_i[1] ? '0 : INT_MIN);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? (special ? S_RESP : S_WAIT) : S_IDLE;
            S_WAIT:  state_d = core_done_i ? S_FIX : S_WAIT;
            S_FIX:   state_d = S_RESP;
            S_RESP:  state_d = bus.resp_ready_i ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    div_sign_fix u_fix (
        .quot      (q_q),
        .rem       (r_q),
        .sign1     (s1_q),
        .sign2     (s2_q),
        .is_signed (~op_q[0]),
        .is_rem    (op_q[1]),
        .res       (fix_res)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            start_q         <= 1'b0;
            op_q            <= '0;
            rd_q            <= '0;
            s1_q            <= 1'b0;
            s2_q            <= 1'b0;
            core_dividend_o <= '0;
            core_divisor_o  <= '0;
            q_q             <= '0;
            r_q             <= '0;
            res_q           <= '0;
        end else begin
            start_q <= accept & ~special;
            if (accept) begin
                op_q            <= bus.op_i;
                rd_q            <= bus.rd_i;
                s1_q            <= neg1;
                s2_q            <= neg2;
                core_dividend_o <= neg1 ? -bus.rs1_i : bus.rs1_i;
                core_divisor_o  <= neg2 ? -bus.rs2_i : bus.rs2_i;
                res_q           <= special_res;
            end
            if (state_q == S_WAIT && core_done_i) begin
                q_q <= core_quot_i;
                r_q <= core_rem_i;
            end
            if (state_q == S_FIX) res_q <= fix_res;
        end
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of div_ctrl against a 3-cycle behavioural divide core.
module tb_div_ctrl;
    import div_ctrl_pkg::*;

    logic        clk_i, rst_n, flush_i;
    logic        core_start_o, core_abort_o, core_done_i;
    logic [31:0] core_dividend_o, core_divisor_o, core_quot_i, core_rem_i;
    logic [31:0] cap_a, cap_b;
    int          cnt, start_cnt, abort_cnt, n_vec, n_err;
    logic        ignore_abort;

    div_ctrl_if bus();

    div_ctrl u_dut (
        .clk_i           (clk_i),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .bus             (bus),
        .core_start_o    (core_start_o),
        .core_abort_o    (core_abort_o),
        .core_dividend_o (core_dividend_o),
        .core_divisor_o  (core_divisor_o),
        .core_done_i     (core_done_i),
        .core_quot_i     (core_quot_i),
        .core_rem_i      (core_rem_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Core model: samples 2ns after the falling edge, done three cycles after start
    initial begin
        cnt = 0; start_cnt = 0; abort_cnt = 0;
        core_done_i = 1'b0; core_quot_i = '0; core_rem_i = '0;
        cap_a = '0; cap_b = '0;
        forever begin
            @(negedge clk_i);
            #2;
            core_done_i = 1'b0;
            if (!rst_n) cnt = 0;
            else begin
                if (core_abort_o) begin
                    abort_cnt++;
                    if (!ignore_abort) cnt = 0;
                end
                if (core_start_o) begin
                    start_cnt++;
                    cap_a = core_dividend_o;
                    cap_b = core_divisor_o;
                    cnt = 3;
                end else if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        core_done_i = 1'b1;
                        core_quot_i = (cap_b == 0) ? '1 : cap_a / cap_b;
                        core_rem_i  = (cap_b == 0) ? cap_a : cap_a % cap_b;
                    end
                end
            end
        end
    end

    task automatic do_op(input div_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic rdy,
                         output logic [31:0] data, output logic [4:0] tag,
                         output int lat, output int starts);
        int s0;
        @(negedge clk_i);
        s0 = start_cnt;
        bus.req_valid_i  = 1'b1;
        bus.op_i         = op;
        bus.rs1_i        = a;
        bus.rs2_i        = b;
        bus.rd_i         = rd;
        bus.resp_ready_i = rdy;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        lat = 1;
        while (!bus.resp_valid_o && lat < 40) begin
            @(negedge clk_i);
            lat++;
        end
        data   = bus.resp_data_o;
        tag    = bus.resp_rd_o;
        starts = start_cnt - s0;
        if (rdy) @(negedge clk_i);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        if (bus.req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", bus.req_ready_o); end
        n_vec++;
        if ({bus.stall_o, bus.resp_valid_o, core_start_o, core_abort_o} !== 4'b0) begin
            n_err++; $display("FAIL reset_ctl got %b exp 0000", {bus.stall_o, bus.resp_valid_o, core_start_o, core_abort_o});
        end
        n_vec++;
        if ({bus.resp_data_o, bus.resp_rd_o, core_dividend_o, core_divisor_o} !== '0) begin
            n_err++; $display("FAIL reset_data got %h/%h/%h/%h exp 0", bus.resp_data_o, bus.resp_rd_o, core_dividend_o, core_divisor_o);
        end
        n_vec++;
        rst_n = 1'b1;
    endtask

    task automatic test_normal;
        logic [31:0] d; logic [4:0] t; int lat, st;
        do_op(OP_DIV, 32'd7, 32'd2, 5'd5, 1'b1, d, t, lat, st);
        if (d !== 32'd3) begin n_err++; $display("FAIL div_7_2 got %h exp 00000003", d); end
        n_vec++;
        if (t !== 5'd5) begin n_err++; $display("FAIL div_tag got %0d exp 5", t); end
        n_vec++;
        if (lat !== 6) begin n_err++; $display("FAIL div_latency got %0d exp 6", lat); end
        n_vec++;
        if (st !== 1) begin n_err++; $display("FAIL div_starts got %0d exp 1", st); end
        n_vec++;
        if ({cap_a, cap_b} !== {32'd7, 32'd2}) begin n_err++; $display("FAIL div_core_ops got %h,%h exp 7,2", cap_a, cap_b); end
        n_vec++;
        do_op(OP_REM, 32'd7, 32'd2, 5'd6, 1'b1, d, t, lat, st);
        if ({d, t} !== {32'd1, 5'd6}) begin n_err++; $display("FAIL rem_7_2 got %h/%0d exp 00000001/6", d, t); end
        n_vec++;
        do_op(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, d, t, lat, st);
        if ({d, lat} !== {32'd0, 32'd6}) begin n_err++; $display("FAIL divu_big got %h lat %0d exp 00000000 lat 6", d, lat); end
        n_vec++;
        do_op(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 1'b1, d, t, lat, st);
        if (d !== 32'h8000_0000) begin n_err++; $display("FAIL remu_big got %h exp 80000000", d); end
        n_vec++;
    endtask

    task automatic test_signed;
        logic [31:0] d; logic [4:0] t; int lat, st;
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, d, t, lat, st);
        if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_m7_2 got %h exp fffffffd", d); end
        n_vec++;
        if ({cap_a, cap_b} !== {32'd7, 32'd2}) begin n_err++; $display("FAIL div_m7_core got %h,%h exp 7,2", cap_a, cap_b); end
        n_vec++;
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd8, 1'b1, d, t, lat, st);
        if (d !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_m7_2 got %h exp ffffffff", d); end
        n_vec++;
        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 5'd9, 1'b1, d, t, lat, st);
        if (d !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_7_m2 got %h exp fffffffd", d); end
        n_vec++;
        if (cap_b !== 32'd2) begin n_err++; $display("FAIL div_7_m2_core got %h exp 2", cap_b); end
        n_vec++;
        do_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 5'd9, 1'b1, d, t, lat, st);
        if (d !== 32'd1) begin n_err++; $display("FAIL rem_7_m2 got %h exp 00000001", d); end
        n_vec++;
    endtask

    task automatic test_special;
        logic [31:0] d; logic [4:0] t; int lat, st;
        do_op(OP_DIVU, 32'd5, 32'd0, 5'd10, 1'b1, d, t, lat, st);
        if ({d, t} !== {32'hFFFF_FFFF, 5'd10}) begin n_err++; $display("FAIL divu_5_0 got %h/%0d exp ffffffff/10", d, t); end
        n_vec++;
        if ({lat, st} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL divu_5_0_timing got lat %0d starts %0d exp 1 0", lat, st); end
        n_vec++;
        do_op(OP_REMU, 32'd5, 32'd0, 5'd11, 1'b1, d, t, lat, st);
        if (d !== 32'd5) begin n_err++; $display("FAIL remu_5_0 got %h exp 00000005", d); end
        n_vec++;
        do_op(OP_REM, 32'hFFFF_FFF9, 32'd0, 5'd12, 1'b1, d, t, lat, st);
        if (d !== 32'hFFFF_FFF9) begin n_err++; $display("FAIL rem_m7_0 got %h exp fffffff9", d); end
        n_vec++;
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b1, d, t, lat, st);
        if (d !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf got %h exp 80000000", d); end
        n_vec++;
        if ({lat, st} !== {32'd1, 32'd0}) begin n_err++; $display("FAIL div_ovf_timing got lat %0d starts %0d exp 1 0", lat, st); end
        n_vec++;
        do_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, d, t, lat, st);
        if (d !== 32'd0) begin n_err++; $display("FAIL rem_ovf got %h exp 00000000", d); end
        n_vec++;
    endtask

    task automatic test_backpressure;
        logic [31:0] d; logic [4:0] t; int lat, st;
        do_op(OP_DIV, 32'd100, 32'd7, 5'd15, 1'b0, d, t, lat, st);
        if (d !== 32'd14) begin n_err++; $display("FAIL bp_data got %h exp 0000000e", d); end
        n_vec++;
        repeat (5) begin
            @(negedge clk_i);
            if ({bus.resp_valid_o, bus.resp_data_o, bus.resp_rd_o} !== {1'b1, 32'd14, 5'd15}) begin
                n_err++; $display("FAIL bp_hold got %b/%h/%0d exp 1/0000000e/15", bus.resp_valid_o, bus.resp_data_o, bus.resp_rd_o);
            end
            n_vec++;
            if ({bus.stall_o, bus.req_ready_o} !== 2'b10) begin
                n_err++; $display("FAIL bp_stall got %b exp 10", {bus.stall_o, bus.req_ready_o});
            end
            n_vec++;
        end
        bus.resp_ready_i = 1'b1;
        @(negedge clk_i);
        if ({bus.resp_valid_o, bus.req_ready_o, bus.stall_o} !== 3'b010) begin
            n_err++; $display("FAIL bp_release got %b exp 010", {bus.resp_valid_o, bus.req_ready_o, bus.stall_o});
        end
        n_vec++;
    endtask

    task automatic test_flush;
        logic [31:0] d; logic [4:0] t; int lat, st, a0, hits;
        ignore_abort = 1'b1;
        a0 = abort_cnt;
        @(negedge clk_i);
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIV; bus.rs1_i = 32'd100; bus.rs2_i = 32'd7; bus.rd_i = 5'd16;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        @(negedge clk_i);
        flush_i = 1'b1;
        #1;
        if ({core_abort_o, bus.stall_o} !== 2'b11) begin n_err++; $display("FAIL flush_abort got %b exp 11", {core_abort_o, bus.stall_o}); end
        n_vec++;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        if ({core_abort_o, bus.stall_o, bus.req_ready_o} !== 3'b001) begin
            n_err++; $display("FAIL flush_idle got %b exp 001", {core_abort_o, bus.stall_o, bus.req_ready_o});
        end
        n_vec++;
        hits = 0;
        repeat (6) begin
            @(negedge clk_i);
            if (bus.resp_valid_o || bus.stall_o) hits++;
        end
        if (hits !== 0) begin n_err++; $display("FAIL flush_no_resp got %0d busy cycles exp 0", hits); end
        n_vec++;
        if (abort_cnt - a0 !== 1) begin n_err++; $display("FAIL flush_abort_count got %0d exp 1", abort_cnt - a0); end
        n_vec++;
        ignore_abort = 1'b0;
        do_op(OP_DIVU, 32'd9, 32'd3, 5'd17, 1'b1, d, t, lat, st);
        if ({d, t, lat} !== {32'd3, 5'd17, 32'd6}) begin
            n_err++; $display("FAIL flush_after got %h/%0d lat %0d exp 00000003/17 lat 6", d, t, lat);
        end
        n_vec++;
    endtask

    task automatic test_flush_idle;
        int s0;
        @(negedge clk_i);
        s0 = start_cnt;
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIVU; bus.rs1_i = 32'd9; bus.rs2_i = 32'd3; bus.rd_i = 5'd18;
        flush_i = 1'b1;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        flush_i = 1'b0;
        #1;
        if ({bus.stall_o, bus.resp_valid_o, bus.req_ready_o} !== 3'b001) begin
            n_err++; $display("FAIL flush_idle_accept got %b exp 001", {bus.stall_o, bus.resp_valid_o, bus.req_ready_o});
        end
        n_vec++;
        @(negedge clk_i);
        if (start_cnt !== s0) begin n_err++; $display("FAIL flush_idle_start got %0d exp %0d", start_cnt, s0); end
        n_vec++;
    endtask

    task automatic test_async_reset;
        @(negedge clk_i);
        bus.req_valid_i = 1'b1; bus.op_i = OP_DIV; bus.rs1_i = 32'd50; bus.rs2_i = 32'd3; bus.rd_i = 5'd19;
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        #1;
        if (bus.stall_o !== 1'b1) begin n_err++; $display("FAIL arst_busy got %b exp 1", bus.stall_o); end
        n_vec++;
        rst_n = 1'b0;
        #1;
        if ({bus.stall_o, bus.req_ready_o, core_start_o, core_dividend_o, bus.resp_rd_o} !== {3'b010, 32'd0, 5'd0}) begin
            n_err++; $display("FAIL arst_clear got %b%b%b/%h/%0d exp 010/00000000/0",
                              bus.stall_o, bus.req_ready_o, core_start_o, core_dividend_o, bus.resp_rd_o);
        end
        n_vec++;
        @(negedge clk_i);
        rst_n = 1'b1;
        repeat (6) @(negedge clk_i);
        if ({bus.stall_o, bus.resp_valid_o} !== 2'b00) begin n_err++; $display("FAIL arst_quiet got %b exp 00", {bus.stall_o, bus.resp_valid_o}); end
        n_vec++;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; flush_i = 1'b0; ignore_abort = 1'b0;
        bus.req_valid_i = 1'b0; bus.op_i = OP_DIV; bus.rs1_i = '0; bus.rs2_i = '0;
        bus.rd_i = '0; bus.resp_ready_i = 1'b1;
        test_reset();
        test_normal();
        test_signed();
        test_special();
        test_backpressure();
        test_flush();
        test_flush_idle();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
